// File: rtl/memsys_pkg.sv
// memsys_pkg: shared types for the memory-system D$ port arbiter.
//   arb_state_e : IDLE / BUSY / HOLD arbiter states
//   arb_mode_e  : fixed-priority or round-robin selection
//   dc_req_t    : one latched D$ request (addr, write, wdata, wlen, virt)
//   idx_width() : index width for an N-entry vector, never below 1 bit
package memsys_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_HOLD = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef struct packed {
        logic [63:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [1:0]  wlen;
        logic        virt;
    } dc_req_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: NUM_REQ-wide mask-based picker.
//   req  : request vector
//   ptr  : round-robin start index (ignored in ARB_FIXED)
//   mode : ARB_FIXED (lowest index wins) or ARB_RR (lowest index >= ptr, wrapping)
//   gnt  : one-hot grant, idx : binary grant index, any : some request present
module rr_arbiter
    import memsys_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  arb_mode_e          mode,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pool;
    logic               found;

    // Requests at or above the pointer get first pick; if none of those are
    // active, fall back to the plain vector, which gives the wrap-around.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_REQ; i++)
            mask[i] = (mode == ARB_RR) && (IDX_W'(i) >= ptr);
        masked = req & mask;
        pool   = (|masked) ? masked : req;
    end

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pool[i] && !found) begin
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
                found  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the single D$ request port among NUM_REQ
// requesters (0 = page-table walker, 1 = core, 2 = spare).
//   req_*   : per-requester request inputs; req_ready is a one-hot grant pulse
//   resp_*  : registered one-hot completion with read data / write flag
//   dc_*    : request to the D$ (driven only in BUSY) and its completion
//   req_lock: owner keeps the port across several accesses while high
module dcache_port_arbiter
    import memsys_pkg::*;
#(
    parameter int        NUM_REQ    = 3,
    parameter arb_mode_e ARB_MODE   = ARB_RR,
    parameter int        LOCK_MAX   = 64,
    parameter int        LOCK_CNT_W = $clog2(LOCK_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0][63:0] req_addr,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ-1:0][63:0] req_wdata,
    input  logic [NUM_REQ-1:0][1:0]  req_wlen,
    input  logic [NUM_REQ-1:0]       req_virt,
    input  logic [NUM_REQ-1:0]       req_lock,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [63:0]              resp_rdata,
    output logic                     resp_is_write,
    output logic                     dc_en,
    output logic [63:0]              dc_addr,
    output logic                     dc_write_en,
    output logic [63:0]              dc_wdata,
    output logic [1:0]               dc_wlen,
    output logic                     dc_virtual_mode,
    input  logic [63:0]              dc_rdata,
    input  logic                     dc_rvalid,
    input  logic                     dc_write_done
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_e          state, state_n;
    dc_req_t             req_q;
    logic [IDX_W-1:0]    owner;
    logic                lock_q;
    logic [IDX_W-1:0]    rr_ptr;
    logic [LOCK_CNT_W-1:0] lock_cnt, lock_cnt_inc;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;

    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    widx;
    logic                take;
    logic                hold_tick;
    logic                done;
    logic                busy;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .mode (ARB_MODE),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    // Read and write completion in the same cycle is a single completion.
    assign done         = dc_rvalid | dc_write_done;
    assign busy         = (state == ARB_BUSY);
    assign lock_cnt_inc = lock_cnt + 1'b1;

    always_comb begin
        state_n   = state;
        grant     = '0;
        take      = 1'b0;
        widx      = arb_idx;
        hold_tick = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (arb_any) begin
                    grant   = arb_gnt;
                    take    = 1'b1;
                    state_n = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (done)
                    state_n = lock_q ? ARB_HOLD : ARB_IDLE;
            end
            ARB_HOLD: begin
                // Lock release wins over a same-cycle owner request; the owner
                // then competes normally from IDLE on the next cycle.
                if (!req_lock[owner]) begin
                    state_n = ARB_IDLE;
                end else if (req_valid[owner]) begin
                    grant[owner] = 1'b1;
                    widx         = owner;
                    take         = 1'b1;
                    state_n      = ARB_BUSY;
                end else if (lock_cnt_inc == LOCK_CNT_W'(LOCK_MAX)) begin
                    // LOCK_MAX-th idle HOLD cycle: force the port free.
                    state_n = ARB_IDLE;
                end else begin
                    hold_tick = 1'b1;
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    // Grant is combinational; gating with reset keeps it low while in reset.
    assign req_ready = grant & {NUM_REQ{reset_n}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ARB_IDLE;
            req_q         <= '0;
            owner         <= '0;
            lock_q        <= 1'b0;
            rr_ptr        <= '0;
            lock_cnt      <= '0;
            resp_valid    <= '0;
            resp_rdata    <= '0;
            resp_is_write <= 1'b0;
        end else begin
            state      <= state_n;
            resp_valid <= '0;

            if (take) begin
                req_q.addr  <= req_addr[widx];
                req_q.write <= req_write[widx];
                req_q.wdata <= req_wdata[widx];
                req_q.wlen  <= req_wlen[widx];
                req_q.virt  <= req_virt[widx];
                owner       <= widx;
                lock_q      <= req_lock[widx];
                lock_cnt    <= '0;
            end

            // Only IDLE grants advance the pointer; locked re-grants do not.
            if (take && state == ARB_IDLE)
                rr_ptr <= (widx == IDX_W'(NUM_REQ - 1)) ? '0 : widx + 1'b1;

            if (hold_tick)
                lock_cnt <= lock_cnt_inc;
            else if (state == ARB_HOLD && state_n == ARB_IDLE)
                lock_cnt <= '0;

            if (busy && done) begin
                resp_valid    <= NUM_REQ'(1) << owner;
                resp_rdata    <= dc_rdata;
                resp_is_write <= req_q.write;
            end
        end
    end

    // dc_* follow the state register, so an async reset drops dc_en at once.
    assign dc_en           = busy;
    assign dc_addr         = busy ? req_q.addr  : '0;
    assign dc_write_en     = busy & req_q.write;
    assign dc_wdata        = busy ? req_q.wdata : '0;
    assign dc_wlen         = busy ? req_q.wlen  : '0;
    assign dc_virtual_mode = busy & req_q.virt;

    always @(posedge clk) begin
        if (reset_n && !busy && (dc_rvalid || dc_write_done))
            $error("dcache_port_arbiter: D$ completion outside BUSY ignored");
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed bench for dcache_port_arbiter.
// A second instance in ARB_FIXED mode shares the stimulus and is held in
// reset except during the fairness sequence.
module tb_dcache_port_arbiter;
    import memsys_pkg::*;

    localparam int N = 3;

    logic              clk = 1'b0;
    logic              reset_n, reset_fx_n;
    logic [N-1:0]      req_valid, req_write, req_virt, req_lock;
    logic [N-1:0][63:0] req_addr, req_wdata;
    logic [N-1:0][1:0] req_wlen;
    logic [63:0]       dc_rdata;
    logic              dc_rvalid, dc_write_done;

    logic [N-1:0]      req_ready, resp_valid;
    logic [63:0]       resp_rdata, dc_addr, dc_wdata;
    logic              resp_is_write, dc_en, dc_write_en, dc_virtual_mode;
    logic [1:0]        dc_wlen;

    logic [N-1:0]      fx_req_ready, fx_resp_valid;
    logic [63:0]       fx_resp_rdata, fx_dc_addr, fx_dc_wdata;
    logic              fx_resp_is_write, fx_dc_en, fx_dc_write_en, fx_dc_virtual_mode;
    logic [1:0]        fx_dc_wlen;

    int n_pass  = 0;
    int n_total = 0;
    int n;

    always #5 clk = ~clk;

    dcache_port_arbiter #(.NUM_REQ(N), .ARB_MODE(ARB_RR), .LOCK_MAX(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_wlen(req_wlen), .req_virt(req_virt),
        .req_lock(req_lock), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_is_write(resp_is_write),
        .dc_en(dc_en), .dc_addr(dc_addr), .dc_write_en(dc_write_en),
        .dc_wdata(dc_wdata), .dc_wlen(dc_wlen), .dc_virtual_mode(dc_virtual_mode),
        .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_write_done(dc_write_done)
    );

    dcache_port_arbiter #(.NUM_REQ(N), .ARB_MODE(ARB_FIXED), .LOCK_MAX(64)) dut_fx (
        .clk(clk), .reset_n(reset_fx_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_wlen(req_wlen), .req_virt(req_virt),
        .req_lock(req_lock), .req_ready(fx_req_ready),
        .resp_valid(fx_resp_valid), .resp_rdata(fx_resp_rdata), .resp_is_write(fx_resp_is_write),
        .dc_en(fx_dc_en), .dc_addr(fx_dc_addr), .dc_write_en(fx_dc_write_en),
        .dc_wdata(fx_dc_wdata), .dc_wlen(fx_dc_wlen), .dc_virtual_mode(fx_dc_virtual_mode),
        .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_write_done(dc_write_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        req_valid     = '0; req_write = '0; req_virt = '0; req_lock = '0;
        req_addr      = '0; req_wdata = '0; req_wlen = '0;
        dc_rdata      = '0; dc_rvalid = 1'b0; dc_write_done = 1'b0;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        reset_fx_n = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        reset_n    = 1'b0;
        reset_fx_n = 1'b0;
        clear_inputs();
        #1;
        req_valid = 3'b010;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_dc_en", dc_en, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_dc_addr", dc_addr, 0);
        req_valid = '0;
        cyc();
        cyc();

        // ---------------- single read ----------------
        req_addr[1] = 64'h1000;
        req_virt[1] = 1'b1;
        req_valid   = 3'b010;
        reset_n     = 1'b1;
        #1;
        chk("rd_ready_T", req_ready, 3'b010);
        cyc();                                   // T+1
        req_valid = '0;
        #1;
        chk("rd_dc_en_T1", dc_en, 1);
        chk("rd_dc_addr", dc_addr, 64'h1000);
        chk("rd_dc_write_en", dc_write_en, 0);
        chk("rd_dc_virt", dc_virtual_mode, 1);
        chk("rd_ready_T1", req_ready, 0);
        cyc();                                   // T+2
        chk("rd_dc_en_T2", dc_en, 1);
        cyc();                                   // T+3
        chk("rd_dc_en_T3", dc_en, 1);
        dc_rvalid = 1'b1;
        dc_rdata  = 64'hDEAD;
        cyc();                                   // T+4
        dc_rvalid = 1'b0;
        dc_rdata  = '0;
        #1;
        chk("rd_resp_valid", resp_valid, 3'b010);
        chk("rd_resp_rdata", resp_rdata, 64'hDEAD);
        chk("rd_resp_is_write", resp_is_write, 0);
        chk("rd_dc_en_T4", dc_en, 0);
        cyc();
        chk("rd_resp_pulse", resp_valid, 0);

        // ---------------- round-robin vs fixed fairness ----------------
        do_reset();
        reset_fx_n = 1'b1;
        req_valid  = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_grant", req_ready, 64'(1) << (k % 3));
            chk("fx_grant", fx_req_ready, 3'b001);
            cyc();
            dc_rvalid = 1'b1;
            dc_rdata  = 64'(k);
            cyc();
            dc_rvalid = 1'b0;
            #1;
            chk("rr_resp_valid", resp_valid, 64'(1) << (k % 3));
            chk("fx_resp_valid", fx_resp_valid, 3'b001);
        end
        req_valid = '0;
        #1;
        chk("rr_no_req", req_ready, 0);

        // ---------------- lock walk ----------------
        do_reset();
        req_valid = 3'b011;
        req_lock  = 3'b001;
        req_virt  = 3'b010;
        for (int i = 0; i < 4; i++) begin
            req_addr[0] = 64'h2000 + 64'(8 * i);
            #1;
            chk("lk_grant0", req_ready, 3'b001);
            cyc();
            chk("lk_dc_virt0", dc_virtual_mode, 0);
            chk("lk_dc_addr", dc_addr, 64'h2000 + 64'(8 * i));
            dc_rvalid = 1'b1;
            dc_rdata  = 64'h100 + 64'(i);
            if (i == 3) begin
                req_lock  = '0;
                req_valid = 3'b010;
            end
            cyc();
            dc_rvalid = 1'b0;
            chk("lk_resp_valid", resp_valid, 3'b001);
            chk("lk_resp_rdata", resp_rdata, 64'h100 + 64'(i));
        end
        #1;
        chk("lk_hold_exit", req_ready, 0);
        cyc();
        #1;
        chk("lk_grant1", req_ready, 3'b010);
        cyc();
        chk("lk_dc_virt1", dc_virtual_mode, 1);
        req_valid = '0;
        dc_rvalid = 1'b1;
        cyc();
        dc_rvalid = 1'b0;
        chk("lk_resp1", resp_valid, 3'b010);

        // ---------------- lock timeout ----------------
        do_reset();
        req_valid = 3'b001;
        req_lock  = 3'b001;
        #1;
        chk("to_grant0", req_ready, 3'b001);
        cyc();
        req_valid = 3'b010;
        dc_rvalid = 1'b1;
        cyc();                                   // first HOLD cycle
        dc_rvalid = 1'b0;
        n = 0;
        while (req_ready !== 3'b010 && n < 200) begin
            cyc();
            n++;
        end
        chk("to_hold_cycles", 64'(n), 64);
        chk("to_grant1", req_ready, 3'b010);

        // ---------------- write with both completions ----------------
        do_reset();
        req_addr[1]  = 64'h3000;
        req_write[1] = 1'b1;
        req_wdata[1] = 64'hCAFE;
        req_wlen[1]  = 2'd3;
        req_virt[1]  = 1'b1;
        req_valid    = 3'b010;
        #1;
        chk("wr_ready", req_ready, 3'b010);
        cyc();
        req_valid = '0;
        req_write = '0;
        req_wdata = '0;
        #1;
        chk("wr_dc_write_en", dc_write_en, 1);
        chk("wr_dc_wdata", dc_wdata, 64'hCAFE);
        chk("wr_dc_wlen", dc_wlen, 3);
        dc_write_done = 1'b1;
        dc_rvalid     = 1'b1;
        dc_rdata      = 64'h1234;
        cyc();
        dc_write_done = 1'b0;
        dc_rvalid     = 1'b0;
        #1;
        chk("wr_resp_valid", resp_valid, 3'b010);
        chk("wr_resp_is_write", resp_is_write, 1);
        chk("wr_dc_en_off", dc_en, 0);
        cyc();
        chk("wr_single_resp", resp_valid, 0);

        // ---------------- reset mid-BUSY ----------------
        do_reset();
        req_valid = 3'b001;
        #1;
        chk("mr_grant0", req_ready, 3'b001);
        cyc();
        req_valid = '0;
        #1;
        chk("mr_dc_en_busy", dc_en, 1);
        reset_n = 1'b0;
        #1;
        chk("mr_dc_en_async", dc_en, 0);
        chk("mr_dc_addr", dc_addr, 0);
        chk("mr_resp_none", resp_valid, 0);
        cyc();
        chk("mr_resp_none2", resp_valid, 0);
        req_valid = 3'b111;
        reset_n   = 1'b1;
        #1;
        chk("mr_ptr_zero", req_ready, 3'b001);
        cyc();
        req_valid = '0;
        chk("mr_busy_again", dc_en, 1);
        chk("mr_resp_none3", resp_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
